// File: rtl/fpu_pkg.sv
// Shared FPU types and constants.
// Result entry layout, opcodes and collector states.
package fpu_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int OP_WIDTH_DEF   = 2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] data;
    logic [OP_WIDTH_DEF-1:0]   opcode;
    logic                      exc;
    logic                      timeout;
  } res_entry_t;

endpackage

// File: rtl/fpu_result_fifo.sv
// Small synchronous result FIFO.
// Power-of-two depth, pointers wrap naturally.
module fpu_result_fifo #(
  parameter  int WIDTH = 36,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;

  assign w_pop   = i_pop && (r_count != '0);
  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

  // Storage write; contents need no reset, count gates validity.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue gating guarantees a push always finds a free slot.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    i_push |-> (r_count != FULL)
  );

endmodule

// File: rtl/fpu_result_collector.sv
// FPU result collector: exception bypass or unit wait
// with timeout, results queued and offered valid/ready.
module fpu_result_collector
  import fpu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int OP_WIDTH   = OP_WIDTH_DEF,
  parameter int TIMEOUT    = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [OP_WIDTH-1:0]   opcode,
  input  logic                  exc_sel,
  input  logic [DATA_WIDTH-1:0] exc_out,
  input  logic                  unit_done,
  input  logic [DATA_WIDTH-1:0] unit_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [OP_WIDTH-1:0]   res_opcode,
  output logic                  res_exc,
  output logic                  res_timeout,
  output logic                  busy
);

  localparam int EW = DATA_WIDTH + OP_WIDTH + 2;
  localparam int TW = $clog2(TIMEOUT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [TW-1:0] TERM = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] NAN_W = DATA_WIDTH'(QNAN);

  state_t              r_state;
  logic [TW-1:0]       r_cnt;
  logic [OP_WIDTH-1:0] r_op;

  logic [CW-1:0] w_count;
  logic          w_valid;
  logic          w_issue;
  logic          w_term;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_wdata;
  logic [EW-1:0] w_rdata;

  assign issue_ready = rst_n && (r_state == IDLE) && (w_count < FULL);
  assign w_issue     = issue_valid && issue_ready;
  assign w_term      = (r_cnt == TERM);
  assign w_valid     = (w_count != '0);
  assign w_pop       = w_valid && res_ready;
  assign busy        = (r_state == WAIT);

  // Select what, if anything, enters the FIFO this cycle.
  always_comb begin
    w_push  = 1'b0;
    w_wdata = '0;
    unique case (r_state)
      IDLE: begin
        if (w_issue && exc_sel) begin
          w_push  = 1'b1;
          w_wdata = {exc_out, opcode, 1'b1, 1'b0};
        end
      end
      WAIT: begin
        if (unit_done) begin
          w_push  = 1'b1;
          w_wdata = {unit_result, r_op, 1'b0, 1'b0};
        end else if (w_term) begin
          w_push  = 1'b1;
          w_wdata = {NAN_W, r_op, 1'b0, 1'b1};
        end
      end
      default: ;
    endcase
  end

  // Issue/wait FSM with timeout counter and latched opcode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_issue && !exc_sel) begin
            r_state <= WAIT;
            r_cnt   <= '0;
            r_op    <= opcode;
          end
        end
        WAIT: begin
          if (unit_done || w_term) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  fpu_result_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_count (w_count)
  );

  assign res_valid   = w_valid;
  assign res_data    = w_valid ? w_rdata[EW-1 -: DATA_WIDTH] : '0;
  assign res_opcode  = w_valid ? w_rdata[2 +: OP_WIDTH] : '0;
  assign res_exc     = w_valid && w_rdata[1];
  assign res_timeout = w_valid && w_rdata[0];

endmodule

// File: doc/fpu_result_collector.md
Name: fpu_result_collector

Overview:
- Sequential stage directly downstream of exception_handler and the four arithmetic units.
- Accepts one operation issue at a time. Takes the exception bypass result (sel/exception_out) when an exception is flagged; otherwise waits for the selected arithmetic unit's done pulse, with a timeout.
- Queues results, tagged with opcode and status, in a small FIFO.
- Presents results on a valid/ready interface to the FPU top-level output.

Parameters:
- DATA_WIDTH, 32, floating-point word width.
- OP_WIDTH, 2, opcode width.
- TIMEOUT, 16, maximum cycles spent waiting for unit_done before a timeout result is forced; must be >= 2.
- FIFO_DEPTH, 2, number of result entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- issue_valid  in  1  an operation is presented this cycle.
- issue_ready  out  1  the collector accepts an issue this cycle.
- opcode  in  OP_WIDTH  operation code: 00 add, 01 sub, 10 mul, 11 div.
- exc_sel  in  1  exception flag from exception_handler for the presented operands.
- exc_out  in  DATA_WIDTH  exception result from exception_handler.
- unit_done  in  1  single-cycle pulse from the active arithmetic unit.
- unit_result  in  DATA_WIDTH  arithmetic unit result, valid while unit_done is high.
- res_valid  out  1  FIFO head is valid.
- res_ready  in  1  downstream consumes the head.
- res_data  out  DATA_WIDTH  head result word.
- res_opcode  out  OP_WIDTH  head opcode.
- res_exc  out  1  head result came from the exception path.
- res_timeout  out  1  head result was forced by the timeout.
- busy  out  1  an operation is in flight (state WAIT).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, counter=0, FIFO empty, read/write pointers 0.
  - res_valid=0, res_data=0, res_opcode=0, res_exc=0, res_timeout=0, busy=0, issue_ready=0 while rst_n is low.
  - Reset mid-operation discards the in-flight operation and all queued results. A unit_done arriving after reset release is ignored.
- issue_ready = (state==IDLE) && (FIFO count < FIFO_DEPTH). This is purely combinational from registered state.
- Issue handshake occurs when issue_valid && issue_ready.
- State IDLE:
  - Handshake with exc_sel=1: push {exc_out, opcode, exc=1, timeout=0} into the FIFO in the same edge; remain in IDLE. Back-to-back exception issues are allowed every cycle while space remains.
  - Handshake with exc_sel=0: latch opcode, clear counter, go to WAIT.
  - unit_done while in IDLE is ignored.
- State WAIT (busy=1, issue_ready=0):
  - unit_done=1: push {unit_result, latched opcode, exc=0, timeout=0}; go to IDLE.
  - Otherwise, if counter==TIMEOUT-1: push {32'h7FC00000, latched opcode, exc=0, timeout=1}; go to IDLE.
  - Otherwise the counter increments.
  - If unit_done and the timeout terminal count coincide, unit_done wins.
- Latency:
  - Exception path: issue at edge N, res_valid visible after edge N (next cycle) when the FIFO was empty.
  - Unit path: unit_done at edge M, res_valid visible in the next cycle.
  - Timeout path: result pushed exactly TIMEOUT cycles after the issue edge.
- FIFO:
  - res_valid = count != 0. Pop when res_valid && res_ready.
  - Simultaneous push and pop: count unchanged, pointers both advance.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push never finds the FIFO full: issue requires free space and only one operation is in flight. This is an invariant and must be asserted.
  - res_* outputs are stable while res_valid && !res_ready.
- Opcode change or issue_valid deassertion while in WAIT has no effect; the latched opcode is used.

Decomposition:
- Shared package fpu_pkg holds:
  - DATA_WIDTH and OP_WIDTH defaults.
  - Opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV.
  - QNAN constant 32'h7FC00000.
  - State encoding IDLE/WAIT.
  - Result entry layout {data, opcode, exc, timeout}.
- One sub-module, fpu_result_fifo: a synchronous FIFO of FIFO_DEPTH entries with push/pop/count and the same clk/rst_n. The FSM and counter stay in the top module.

Test Plan:
- Reset mid-WAIT: issue add with exc_sel=0, assert rst_n=0 two cycles later, then pulse unit_done after release -> res_valid stays 0, state IDLE, busy=0.
- Exception bypass: issue div with exc_sel=1, exc_out=32'h7F800000, res_ready=1 -> next cycle res_valid=1, res_data=7F800000, res_opcode=11, res_exc=1; no WAIT entered.
- Unit path: issue mul with exc_sel=0, unit_done with unit_result=32'h40C00000 after 5 cycles -> busy=1 for 5 cycles, then res_data=40C00000, res_opcode=10, res_exc=0, res_timeout=0.
- Timeout (TIMEOUT=16): issue sub, never assert unit_done -> result pushed 16 cycles after issue with res_data=7FC00000, res_timeout=1, res_opcode=01. A second case with unit_done on the terminal cycle -> unit_result wins, res_timeout=0.
- Backpressure/full: res_ready=0, two exception issues -> issue_ready=0 with count=2. Hold 3 cycles and check outputs stable. Raise res_ready -> heads pop in order, then issue_ready returns to 1.
- Simultaneous push/pop: FIFO holds 1 entry, res_ready=1 while unit_done arrives -> count stays 1 and entry order is preserved.
